// File: rtl/reg_fifo_pkg.sv
// Shared constants and types for the reg_mem streaming FIFO controller.
// Defaults match an 8-bit, 32-deep reg_mem.
package reg_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS  = 5;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

  function automatic int calc_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/reg_fifo_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (write vs read) for the single memory port.
// Zero-latency grant; remembers the last winner, resetting to "read" so write wins first.
module rr_arb2
  import reg_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_wr,
  input  logic i_req_rd,
  output gnt_e o_gnt
);

  logic r_last_rd;
  gnt_e w_gnt;

  always_comb begin
    w_gnt = GNT_NONE;
    if (i_req_wr && i_req_rd) begin
      w_gnt = r_last_rd ? GNT_WR : GNT_RD;
    end else if (i_req_wr) begin
      w_gnt = GNT_WR;
    end else if (i_req_rd) begin
      w_gnt = GNT_RD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_rd <= 1'b1;
    end else if (w_gnt == GNT_WR) begin
      r_last_rd <= 1'b0;
    end else if (w_gnt == GNT_RD) begin
      r_last_rd <= 1'b1;
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/reg_mem.sv
// Single-port register memory: synchronous write, asynchronous read.
// No reset on the array; contents are only meaningful once written.
module reg_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) begin
      r_mem[addr] <= data_in;
    end
  end

  assign data_out = r_mem[addr];

endmodule

// File: rtl/reg_fifo_ctrl.sv
// Valid/ready FIFO over single-port reg_mem with a one-word prefetch output register.
// Empty-to-out_valid latency 2 cycles; in_ready only on a granted write, capacity DEPTH+1.
module reg_fifo_ctrl
  import reg_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADDR_BITS:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int                 DEPTH     = calc_depth(ADDR_BITS);
  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(DEPTH);

  logic [ADDR_BITS-1:0]  r_wr_ptr;
  logic [ADDR_BITS-1:0]  r_rd_ptr;
  logic [ADDR_BITS:0]    r_mem_cnt;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic w_want_wr;
  logic w_want_rd;
  gnt_e w_gnt;

  // Requests are masked during reset so reg_mem is never written while state is clearing.
  assign w_want_wr = !rst && in_valid && (r_mem_cnt < DEPTH_CNT);
  assign w_want_rd = !rst && (r_mem_cnt != '0) && (!r_out_valid || out_ready);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req_wr (w_want_wr),
    .i_req_rd (w_want_rd),
    .o_gnt    (w_gnt)
  );

  assign in_ready  = (w_gnt == GNT_WR);
  assign mem_wen   = (w_gnt == GNT_WR);
  assign mem_addr  = (w_gnt == GNT_WR) ? r_wr_ptr : r_rd_ptr;
  assign mem_din   = in_data;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign count     = r_mem_cnt + (ADDR_BITS+1)'(r_out_valid);
  assign full      = (r_mem_cnt == DEPTH_CNT);
  assign empty     = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_gnt == GNT_WR) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_mem_cnt <= r_mem_cnt + 1'b1;
      end else if (w_gnt == GNT_RD) begin
        // A consumer pop in the same cycle is covered by the refill word.
        r_out_data  <= mem_dout;
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_mem_cnt   <= r_mem_cnt - 1'b1;
      end
      if ((w_gnt != GNT_RD) && r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
